// File: rtl/stopwatch_pkg.sv
// Shared BCD types and helpers for the up/down stopwatch/timer.
package stopwatch_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_ZERO = 4'd0;
  localparam bcd_t BCD_NINE = 4'd9;

  function automatic bcd_t bcd_clamp(input bcd_t n);
    return (n > BCD_NINE) ? BCD_NINE : n;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the up/down counter chain: steps on step_in, reports its own
// limit (9 up / 0 down) and passes carry/borrow to the next digit.
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_digit,
  input  logic       up,
  input  logic       step_in,
  input  logic       hold,
  output logic [3:0] digit,
  output logic       at_lim,
  output logic       carry_out
);

  assign at_lim    = up ? (digit == BCD_NINE) : (digit == BCD_ZERO);
  assign carry_out = step_in && at_lim;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      digit <= BCD_ZERO;
    end else if (load) begin
      digit <= bcd_clamp(load_digit);
    end else if (step_in && !hold) begin
      if (up)
        digit <= (digit == BCD_NINE) ? BCD_ZERO : digit + 4'd1;
      else
        digit <= (digit == BCD_ZERO) ? BCD_NINE : digit - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_updown_timer.sv
// N-digit BCD up/down stopwatch/timer with prescaler, wrap/saturate limits,
// load/clear and rollover flag. Optional lap hold display: define LAP_HOLD_EN.
module bcd_updown_timer
  import stopwatch_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 10000000,
  parameter int WRAP       = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    up,
  input  logic                    clear,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
`ifdef LAP_HOLD_EN
  input  logic                    lap,
`endif
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    tick,
  output logic                    at_limit,
  output logic                    rollover
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam bit SATURATE = (WRAP == 0);

  logic [PW-1:0]             presc;
  logic [4*NUM_DIGITS-1:0]   count;
  logic [NUM_DIGITS-1:0]     at_lim_d;
  logic [NUM_DIGITS:0]       step;
  logic                      hold;

  assign tick     = enable && (presc == PRESC_LAST);
  assign at_limit = &at_lim_d;
  assign hold     = SATURATE && at_limit;
  assign step[0]  = tick;

  always_ff @(posedge clk) begin
    if (reset || clear || load)
      presc <= '0;
    else if (enable)
      presc <= tick ? '0 : presc + PW'(1);
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk        (clk),
      .reset      (reset),
      .clear      (clear),
      .load       (load),
      .load_digit (load_value[4*i +: 4]),
      .up         (up),
      .step_in    (step[i]),
      .hold       (hold),
      .digit      (count[4*i +: 4]),
      .at_lim     (at_lim_d[i]),
      .carry_out  (step[i+1])
    );
  end

  // Carry out of the top digit is exactly "tick taken while every digit sits at its limit".
  always_ff @(posedge clk) begin
    if (reset || clear || load)
      rollover <= 1'b0;
    else
      rollover <= step[NUM_DIGITS];
  end

`ifdef LAP_HOLD_EN
  logic                    lap_active;
  logic [4*NUM_DIGITS-1:0] lap_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      lap_active <= 1'b0;
      lap_reg    <= '0;
    end else begin
      lap_active <= lap;
      if (clear)
        lap_reg <= '0;
      else if (lap && !lap_active)
        lap_reg <= count;
    end
  end

  assign digits = lap_active ? lap_reg : count;
`else
  assign digits = count;
`endif

endmodule

// File: tb/tb_bcd_updown_timer.sv
// Randomized + directed bench for bcd_updown_timer (2 digits, TICK_DIV=4), one
// wrapping and one saturating instance against an integer reference model.
module tb_bcd_updown_timer;

  logic       clk = 1'b0;
  logic       reset = 1'b1, enable = 1'b0, up = 1'b1, clear = 1'b0, load = 1'b0;
  logic [7:0] load_value = 8'h00;
`ifdef LAP_HOLD_EN
  logic       lap = 1'b0;
`endif
  logic [7:0] dig_w, dig_s;
  logic       tick_w, tick_s, lim_w, lim_s, roll_w, roll_s;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state (plain integers 0..99)
  int m_cnt_w = 0, m_cnt_s = 0, m_presc = 0, m_lap = 0;
  bit m_roll_w = 0, m_roll_s = 0, m_lap_act = 0;

  always #5 clk = ~clk;

  bcd_updown_timer #(.NUM_DIGITS(2), .TICK_DIV(4), .WRAP(1)) u_wrap (
    .clk(clk), .reset(reset), .enable(enable), .up(up), .clear(clear), .load(load),
    .load_value(load_value),
`ifdef LAP_HOLD_EN
    .lap(lap),
`endif
    .digits(dig_w), .tick(tick_w), .at_limit(lim_w), .rollover(roll_w));

  bcd_updown_timer #(.NUM_DIGITS(2), .TICK_DIV(4), .WRAP(0)) u_sat (
    .clk(clk), .reset(reset), .enable(enable), .up(up), .clear(clear), .load(load),
    .load_value(load_value),
`ifdef LAP_HOLD_EN
    .lap(lap),
`endif
    .digits(dig_s), .tick(tick_s), .at_limit(lim_s), .rollover(roll_s));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic int load_to_int(input logic [7:0] b);
    int hi, lo;
    hi = int'(b[7:4]);
    lo = int'(b[3:0]);
    if (hi > 9) hi = 9;
    if (lo > 9) lo = 9;
    return hi * 10 + lo;
  endfunction

  function automatic int next_val(input int c, input bit u, input bit wrap);
    if (u) return (c == 99) ? (wrap ? 0 : 99) : c + 1;
    else   return (c == 0)  ? (wrap ? 99 : 0) : c - 1;
  endfunction

  // Drive one cycle of inputs, check outputs against the model, then advance the model.
  task automatic cycle(input bit rst, input bit en, input bit u, input bit clr,
                       input bit ld, input logic [7:0] lv, input bit lp);
    bit m_tick;
    int lap_v;
    @(negedge clk);
    reset = rst; enable = en; up = u; clear = clr; load = ld; load_value = lv;
`ifdef LAP_HOLD_EN
    lap = lp;
    lap_v = lp ? 1 : 0;
`else
    lap_v = 0;
`endif
    #1;
    m_tick = en && (m_presc == 3);
    check("tick_w", 32'(tick_w), 32'(m_tick));
    check("tick_s", 32'(tick_s), 32'(m_tick));
    check("lim_w", 32'(lim_w), 32'(u ? (m_cnt_w == 99) : (m_cnt_w == 0)));
    check("lim_s", 32'(lim_s), 32'(u ? (m_cnt_s == 99) : (m_cnt_s == 0)));
    check("roll_w", 32'(roll_w), 32'(m_roll_w));
    check("roll_s", 32'(roll_s), 32'(m_roll_s));
    check("dig_w", 32'(dig_w), 32'(m_lap_act ? to_bcd(m_lap) : to_bcd(m_cnt_w)));
    check("dig_s", 32'(dig_s), 32'(m_lap_act ? to_bcd(m_lap) : to_bcd(m_cnt_s)));
    if (rst) begin
      m_cnt_w = 0; m_cnt_s = 0; m_presc = 0; m_roll_w = 0; m_roll_s = 0;
      m_lap_act = 0; m_lap = 0;
    end else begin
      if (clr) m_lap = 0;
      else if (lap_v == 1 && !m_lap_act) m_lap = m_cnt_w;
      m_lap_act = (lap_v == 1);
      if (clr) begin
        m_cnt_w = 0; m_cnt_s = 0; m_presc = 0; m_roll_w = 0; m_roll_s = 0;
      end else if (ld) begin
        m_cnt_w = load_to_int(lv); m_cnt_s = load_to_int(lv); m_presc = 0;
        m_roll_w = 0; m_roll_s = 0;
      end else begin
        m_roll_w = m_tick && (u ? (m_cnt_w == 99) : (m_cnt_w == 0));
        m_roll_s = m_tick && (u ? (m_cnt_s == 99) : (m_cnt_s == 0));
        if (m_tick) begin
          m_cnt_w = next_val(m_cnt_w, u, 1'b1);
          m_cnt_s = next_val(m_cnt_s, u, 1'b0);
        end
        if (en) m_presc = m_tick ? 0 : m_presc + 1;
      end
    end
  endtask

  initial begin
    int ticks, rolls, first_tick;
    bit r_lap;
    repeat (2) @(posedge clk);

    // reset state
    cycle(1, 0, 1, 0, 0, 8'h00, 0);
    check("reset_digits", 32'(dig_w), 32'h00);
    check("reset_roll", 32'(roll_w), 32'h0);

    // count up 40 cycles from reset
    ticks = 0; rolls = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(0, 1, 1, 0, 0, 8'h00, 0);
      ticks += tick_w ? 1 : 0;
      rolls += roll_w ? 1 : 0;
    end
    cycle(0, 0, 1, 0, 0, 8'h00, 0);
    check("t1_digits", 32'(dig_w), 32'h10);
    check("t1_ticks", 32'(ticks), 32'd10);
    check("t1_rolls", 32'(rolls), 32'd0);

    // wrap up from 99
    cycle(0, 1, 1, 0, 1, 8'h99, 0);
    repeat (4) cycle(0, 1, 1, 0, 0, 8'h00, 0);
    cycle(0, 1, 1, 0, 0, 8'h00, 0);
    check("t2_wrap_digits", 32'(dig_w), 32'h00);
    check("t2_sat_digits", 32'(dig_s), 32'h99);
    check("t2_roll_hi", 32'(roll_w), 32'h1);
    cycle(0, 1, 1, 0, 0, 8'h00, 0);
    check("t2_roll_lo", 32'(roll_w), 32'h0);

    // saturate down at 00
    cycle(0, 1, 0, 0, 1, 8'h00, 0);
    rolls = 0;
    for (int i = 0; i < 13; i++) begin
      cycle(0, 1, 0, 0, 0, 8'h00, 0);
      rolls += roll_s ? 1 : 0;
    end
    check("t3_digits", 32'(dig_s), 32'h00);
    check("t3_limit", 32'(lim_s), 32'h1);
    check("t3_rolls", 32'(rolls), 32'd3);

    // load clamp, load+clear, load over tick
    cycle(0, 0, 1, 0, 1, 8'h5F, 0);
    cycle(0, 0, 1, 0, 0, 8'h00, 0);
    check("t4_clamp", 32'(dig_w), 32'h59);
    cycle(0, 0, 1, 1, 1, 8'h33, 0);
    cycle(0, 0, 1, 0, 0, 8'h00, 0);
    check("t4_clear_wins", 32'(dig_w), 32'h00);
    repeat (3) cycle(0, 1, 1, 0, 0, 8'h00, 0);
    cycle(0, 1, 1, 0, 1, 8'h42, 0);
    check("t4_tick_coinc", 32'(tick_w), 32'h1);
    cycle(0, 0, 1, 0, 0, 8'h00, 0);
    check("t4_load_tick", 32'(dig_w), 32'h42);

    // pause at prescaler=2 for 3 cycles
    cycle(0, 1, 1, 0, 1, 8'h30, 0);
    first_tick = 0;
    for (int i = 1; i <= 10; i++) begin
      cycle(0, !(i >= 3 && i <= 5), 1, 0, 0, 8'h00, 0);
      if (tick_w && first_tick == 0) begin
        first_tick = i;
        check("t5_count_held", 32'(dig_w), 32'h30);
      end
    end
    check("t5_tick_delay", 32'(first_tick), 32'd7);

`ifdef LAP_HOLD_EN
    cycle(0, 0, 1, 0, 1, 8'h12, 0);
    for (int i = 0; i < 20; i++) cycle(0, 1, 1, 0, 0, 8'h00, 1);
    check("t6_lap_hold", 32'(dig_w), 32'h12);
    cycle(0, 0, 1, 0, 0, 8'h00, 0);
    cycle(0, 0, 1, 0, 0, 8'h00, 0);
    check("t6_lap_release", 32'(dig_w), 32'h17);
`endif

    // randomized traffic
    r_lap = 0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(7) == 0) r_lap = !r_lap;
      cycle($urandom_range(63) == 0, $urandom_range(3) != 0, 1'($urandom_range(1)),
            $urandom_range(31) == 0, $urandom_range(15) == 0, 8'($urandom), r_lap);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
